// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//
// Read-side drain stage for the synchronous byte FIFO. Bytes are pulled with
// single-cycle active-low read strobes, packed PACK_RATIO at a time into one
// wide word (first byte in lane 0, the least significant lane) and presented
// on a valid/ready stream. A flush request emits the current partial word
// together with a lane-keep mask.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   fifo_empty  in   registered FIFO empty flag (one edge late)
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd_n is low
//   fifo_rd_n   out  registered active-low read strobe
//   flush       in   single-cycle request to emit the partial word
//   m_data      out  packed word, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   m_keep      out  per-lane valid mask
//   m_valid     out  m_data/m_keep valid
//   m_ready     in   downstream accept
//   busy        out  state not POLL, or lanes assembled, or word pending
// -----------------------------------------------------------------------------
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_dout,
    output logic                             fifo_rd_n,
    input  logic                             flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]            m_keep,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             busy
);

    localparam int CW = $clog2(PACK_RATIO + 1);
    localparam int WW = DATA_WIDTH * PACK_RATIO;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_POLL,
        ST_READ,
        ST_CAPTURE
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [WW-1:0]           asm_q, asm_d;
    logic                    pend_q, pend_d;
    logic                    rd_n_q, rd_n_d;
    logic [WW-1:0]           m_data_q, m_data_d;
    logic [PACK_RATIO-1:0]   m_keep_q, m_keep_d;
    logic                    m_valid_q, m_valid_d;

    logic                    out_free;
    logic                    count_full;
    logic [PACK_RATIO-1:0]   keep_mask;

    assign out_free   = !m_valid_q || m_ready;
    assign count_full = (count_q == CW'(PACK_RATIO));

    // Lanes below the assembly count hold captured bytes.
    always_comb begin
        keep_mask = '0;
        for (int k = 0; k < PACK_RATIO; k++) begin
            keep_mask[k] = (CW'(k) < count_q);
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        logic xfer;
        logic pend_clear;

        state_d    = state_q;
        count_d    = count_q;
        asm_d      = asm_q;
        rd_n_d     = 1'b1;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_valid_d  = m_valid_q && !m_ready;
        xfer       = 1'b0;
        pend_clear = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                // fifo_empty still shows its reset value here; do not trust it.
                state_d = ST_POLL;
            end
            ST_POLL: begin
                if (count_full) begin
                    xfer = out_free;
                end else if (pend_q) begin
                    if (count_q == '0) begin
                        pend_clear = 1'b1;
                    end else begin
                        xfer = out_free;
                    end
                end else if (!fifo_empty) begin
                    rd_n_d  = 1'b0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                for (int k = 0; k < PACK_RATIO; k++) begin
                    if (count_q == CW'(k)) begin
                        asm_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
                    end
                end
                count_d = count_q + CW'(1);
                state_d = ST_POLL;
            end
            default: state_d = ST_INIT;
        endcase

        // Unused lanes are already zero: the assembly is cleared on every
        // transfer and lanes fill in order.
        if (xfer) begin
            m_data_d   = asm_q;
            m_keep_d   = keep_mask;
            m_valid_d  = 1'b1;
            count_d    = '0;
            asm_d      = '0;
            pend_clear = 1'b1;
        end

        // A flush landing on the clearing edge is kept for the next word.
        pend_d = (pend_q && !pend_clear) || flush;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    // NOTE: the assembly and output word are reset too, so a reset always
    // discards partial data and the outputs start from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            count_q   <= '0;
            asm_q     <= '0;
            pend_q    <= 1'b0;
            rd_n_q    <= 1'b1;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            asm_q     <= asm_d;
            pend_q    <= pend_d;
            rd_n_q    <= rd_n_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign fifo_rd_n = rd_n_q;
    assign m_data    = m_data_q;
    assign m_keep    = m_keep_q;
    assign m_valid   = m_valid_q;
    assign busy      = (state_q != ST_POLL) || (count_q != '0) || m_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
//
// Directed bench for fifo_word_packer. A behavioural byte FIFO (queue with a
// one-edge-late empty flag and registered read data) feeds the DUT; a negedge
// monitor records strobe cycles and accepted words for the scenario tasks.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_n;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fifo_word_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_n  (fifo_rd_n),
        .flush      (flush),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: empty reflects the queue as it stood before this edge.
    logic [7:0] fq[$];
    int         underflow = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_empty <= 1'b0;
            fifo_dout  <= 8'h00;
        end else begin
            fifo_empty <= (fq.size() == 0);
            if (!fifo_rd_n) begin
                if (fq.size() > 0) fifo_dout <= fq.pop_front();
                else               underflow <= underflow + 1;
            end
        end
    end

    // Monitor: strobe cycles, strobe width, accepted words.
    int          cycle = 0;
    int          strobes[$];
    logic [31:0] words[$];
    logic [3:0]  keeps[$];
    logic        prev_low = 1'b0;
    int          width_err = 0;

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (!fifo_rd_n) strobes.push_back(cycle);
        if (!fifo_rd_n && prev_low) width_err <= width_err + 1;
        prev_low <= !fifo_rd_n;
        if (m_valid && m_ready) begin
            words.push_back(m_data);
            keeps.push_back(m_keep);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int i = 0;
        while (words.size() < n && i < budget) begin
            tick(1);
            i++;
        end
        if (words.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout, got %0d words, required %0d", name, words.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while ((busy || m_valid) && i < 50) begin
            tick(1);
            i++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: busy=%b, required 0", name, busy);
        end
    endtask

    task automatic check_word(input int idx, input logic [31:0] exp_d,
                              input logic [3:0] exp_k, input string name);
        n_cmp++;
        if (idx >= words.size()) begin
            n_err++;
            $display("FAIL %s: word %0d missing", name, idx);
        end else if (words[idx] !== exp_d || keeps[idx] !== exp_k) begin
            n_err++;
            $display("FAIL %s: data=%h keep=%h, required data=%h keep=%h",
                     name, words[idx], keeps[idx], exp_d, exp_k);
        end
    endtask

    task automatic test_reset();
        fq.push_back(8'hE1);
        fq.push_back(8'hE2);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        // Assert reset in the middle of a cycle, away from any edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (fifo_rd_n !== 1'b1 || m_valid !== 1'b0 || m_data !== 32'h0 ||
            m_keep !== 4'h0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_values: rd_n=%b valid=%b data=%h keep=%h busy=%b, required 1 0 0 0 1",
                     fifo_rd_n, m_valid, m_data, m_keep, busy);
        end
        fq.delete();
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i * 17));
        tick(2);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rd_n !== 1'b1) begin
            n_err++;
            $display("FAIL init_no_read: rd_n=%b, required 1", fifo_rd_n);
        end
        tick(1);
        n_cmp++;
        if (fifo_rd_n !== 1'b1) begin
            n_err++;
            $display("FAIL poll_no_read: rd_n=%b, required 1", fifo_rd_n);
        end
        tick(1);
        n_cmp++;
        if (fifo_rd_n !== 1'b0) begin
            n_err++;
            $display("FAIL first_read: rd_n=%b, required 0", fifo_rd_n);
        end
    endtask

    task automatic test_stream(input int sb, input int wb);
        wait_words(wb + 2, 60, "stream_words");
        check_word(wb,     32'h44332211, 4'hF, "stream_word0");
        check_word(wb + 1, 32'h88776655, 4'hF, "stream_word1");
        wait_idle("stream_idle");
        n_cmp++;
        if (strobes.size() - sb != 8) begin
            n_err++;
            $display("FAIL stream_strobes: %0d, required 8", strobes.size() - sb);
        end else begin
            for (int i = 0; i < 7; i++) begin
                // Word boundary costs one extra POLL cycle for the transfer.
                int exp_gap = (i == 3) ? 4 : 3;
                n_cmp++;
                if (strobes[sb+i+1] - strobes[sb+i] != exp_gap) begin
                    n_err++;
                    $display("FAIL stream_gap%0d: %0d cycles, required %0d",
                             i, strobes[sb+i+1] - strobes[sb+i], exp_gap);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int sb = strobes.size();
        int wb = words.size();
        m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
        tick(60);
        n_cmp++;
        if (strobes.size() - sb != 8 || m_valid !== 1'b1 || m_data !== 32'h04030201 ||
            m_keep !== 4'hF || fifo_rd_n !== 1'b1) begin
            n_err++;
            $display("FAIL bp_stall: strobes=%0d valid=%b data=%h keep=%h rd_n=%b, required 8 1 04030201 f 1",
                     strobes.size() - sb, m_valid, m_data, m_keep, fifo_rd_n);
        end
        m_ready = 1'b1;
        wait_words(wb + 3, 60, "bp_words");
        check_word(wb,     32'h04030201, 4'hF, "bp_word0");
        check_word(wb + 1, 32'h08070605, 4'hF, "bp_word1");
        check_word(wb + 2, 32'h0C0B0A09, 4'hF, "bp_word2");
        wait_idle("bp_idle");
        n_cmp++;
        if (words.size() - wb != 3 || strobes.size() - sb != 12) begin
            n_err++;
            $display("FAIL bp_totals: words=%0d strobes=%0d, required 3 12",
                     words.size() - wb, strobes.size() - sb);
        end
    endtask

    task automatic test_flush();
        int wb = words.size();
        fq.push_back(8'hA1);
        fq.push_back(8'hA2);
        fq.push_back(8'hA3);
        tick(20);
        pulse_flush();
        wait_words(wb + 1, 10, "flush_word");
        check_word(wb, 32'h00A3A2A1, 4'h7, "flush_partial");
        wait_idle("flush_idle");
        pulse_flush();
        tick(5);
        n_cmp++;
        if (words.size() != wb + 1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_empty: words=%0d valid=%b busy=%b, required %0d 0 0",
                     words.size(), m_valid, busy, wb + 1);
        end
    endtask

    task automatic test_flush_in_read();
        int wb = words.size();
        int i = 0;
        fq.push_back(8'h5A);
        tick(10);
        fq.push_back(8'h5B);
        fq.push_back(8'h5C);
        while (fifo_rd_n !== 1'b0 && i < 10) begin
            tick(1);
            i++;
        end
        n_cmp++;
        if (fifo_rd_n !== 1'b0) begin
            n_err++;
            $display("FAIL flush_read_strobe: rd_n=%b, required 0", fifo_rd_n);
        end
        pulse_flush();
        wait_words(wb + 1, 15, "flush_read_word");
        check_word(wb, 32'h00005B5A, 4'h3, "flush_read_partial");
        fq.push_back(8'h5D);
        fq.push_back(8'h5E);
        fq.push_back(8'h5F);
        wait_words(wb + 2, 40, "resume_word");
        check_word(wb + 1, 32'h5F5E5D5C, 4'hF, "resume_full");
        wait_idle("resume_idle");
    endtask

    task automatic test_empty();
        int sb = strobes.size();
        int wb = words.size();
        tick(50);
        n_cmp++;
        if (strobes.size() != sb) begin
            n_err++;
            $display("FAIL empty_no_strobe: %0d strobes, required 0", strobes.size() - sb);
        end
        fq.push_back(8'h77);
        tick(1);
        n_cmp++;
        if (fifo_rd_n !== 1'b1) begin
            n_err++;
            $display("FAIL empty_fall_wait: rd_n=%b, required 1", fifo_rd_n);
        end
        tick(1);
        n_cmp++;
        if (fifo_rd_n !== 1'b0) begin
            n_err++;
            $display("FAIL empty_fall_read: rd_n=%b, required 0", fifo_rd_n);
        end
        tick(3);
        pulse_flush();
        wait_words(wb + 1, 10, "single_word");
        check_word(wb, 32'h00000077, 4'h1, "single_partial");
        wait_idle("single_idle");
    endtask

    initial begin
        int sb;
        int wb;
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        tick(2);
        test_reset();
        // Reset release happened two cycles before the first strobe.
        sb = strobes.size();
        wb = words.size();
        test_stream(sb, wb);
        test_backpressure();
        test_flush();
        test_flush_in_read();
        test_empty();
        n_cmp++;
        if (width_err != 0 || underflow != 0) begin
            n_err++;
            $display("FAIL strobe_health: wide=%0d underflow=%0d, required 0 0", width_err, underflow);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
